// File: rtl/echo_delay_ctrl.sv
// rtl/echo_delay_ctrl.sv - echo delay-line sequencer driving an external 2-cycle-latency sample RAM
module echo_delay_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] delay,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_sample,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_delayed,
  output logic [DATA_WIDTH-1:0] out_mix,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  typedef enum logic [1:0] {IDLE, RD, WAIT, CAP} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic [DATA_WIDTH-1:0] sample_q;
  logic                  bypass_q;
  logic                  unwritten_q;
  logic                  accept;
  logic [DATA_WIDTH-1:0] delayed_val;
  logic [DATA_WIDTH:0]   mix_sum;

  assign accept = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RD;
      end
      RD:      state_nxt = WAIT;
      WAIT:    state_nxt = CAP;
      CAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write is combinational so a clear landing in CAP suppresses it in the same cycle.
  assign ram_wr_en   = (state == CAP) & ~clear;
  assign ram_wr_addr = wptr;
  assign ram_wr_data = sample_q;

  always_comb begin
    delayed_val = ram_rd_data;
    if (bypass_q)         delayed_val = sample_q;
    else if (unwritten_q) delayed_val = '0;
  end

  // Sign-extend by one bit, add, then drop the LSB: arithmetic shift right by one.
  assign mix_sum = {sample_q[DATA_WIDTH-1], sample_q} + {delayed_val[DATA_WIDTH-1], delayed_val};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wptr        <= '0;
      fill_cnt    <= '0;
      sample_q    <= '0;
      bypass_q    <= 1'b0;
      unwritten_q <= 1'b0;
      ram_rd_addr <= '0;
      out_valid   <= 1'b0;
      out_delayed <= '0;
      out_mix     <= '0;
    end else if (clear) begin
      state     <= IDLE;
      wptr      <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      if (accept) begin
        sample_q    <= in_sample;
        bypass_q    <= (delay == '0);
        unwritten_q <= (delay > fill_cnt);
        ram_rd_addr <= wptr - delay;
      end
      if (state == CAP) begin
        wptr        <= wptr + 1'b1;
        if (fill_cnt != '1) fill_cnt <= fill_cnt + 1'b1;
        out_valid   <= 1'b1;
        out_delayed <= delayed_val;
        out_mix     <= mix_sum[DATA_WIDTH:1];
      end
    end
  end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// tb/tb_echo_delay_ctrl.sv - scoreboard bench for echo_delay_ctrl with a behavioural 2-cycle RAM
module tb_echo_delay_ctrl;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [AW-1:0] delay = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_sample = '0;
  logic          out_valid;
  logic [DW-1:0] out_delayed, out_mix;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data, rd_q1;

  echo_delay_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .delay(delay),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .out_valid(out_valid), .out_delayed(out_delayed), .out_mix(out_mix),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    rd_q1       <= mem[ram_rd_addr];
    ram_rd_data <= rd_q1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] ed;
    logic [DW-1:0] em;
    int            t;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [AW-1:0] d;
    logic [DW-1:0] s;
    logic [DW-1:0] ed;
    logic [DW-1:0] em;
  } vec_t;
  vec_t tbl[13];

  logic [DW-1:0] hist[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mix_of(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sum;
    sum = (int'($signed(a)) + int'($signed(b))) >>> 1;
    return sum[DW-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
      else begin
        sb_t e;
        e = sb.pop_front();
        chk("out_delayed", {16'd0, out_delayed}, {16'd0, e.ed});
        chk("out_mix", {16'd0, out_mix}, {16'd0, e.em});
        chk("out_valid_latency", cyc - e.t, 32'd4);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
  endtask

  // Called and returns on a falling edge; leaves off at T+3 after the CAP write.
  task automatic send(input logic [AW-1:0] d, input logic [DW-1:0] s,
                      input logic [DW-1:0] ed, input logic [DW-1:0] em,
                      input bit chg, input logic [AW-1:0] nd);
    sb_t e;
    wait_ready();
    delay = d; in_sample = s; in_valid = 1'b1;
    e.ed = ed; e.em = em; e.t = cyc;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_t1", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("in_ready_t2", {31'd0, in_ready}, 32'd0);
    if (chg) delay = nd;
    @(negedge clk);
    chk("in_ready_t3", {31'd0, in_ready}, 32'd0);
    chk("ram_wr_en", {31'd0, ram_wr_en}, 32'd1);
    chk("ram_wr_addr", {22'd0, ram_wr_addr}, hist.size() % 1024);
    chk("ram_wr_data", {16'd0, ram_wr_data}, {16'd0, s});
    hist.push_back(s);
  endtask

  task automatic accept_only(input logic [AW-1:0] d, input logic [DW-1:0] s);
    wait_ready();
    delay = d; in_sample = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] ed;
    for (int i = 0; i < 1024; i++) mem[i] = 16'hDEAD;
    tbl[0]  = '{10'd3,  16'd1,      16'd0,      16'd0};
    tbl[1]  = '{10'd3,  16'd2,      16'd0,      16'd1};
    tbl[2]  = '{10'd3,  16'd3,      16'd0,      16'd1};
    tbl[3]  = '{10'd3,  16'd4,      16'd1,      16'd2};
    tbl[4]  = '{10'd3,  16'd5,      16'd2,      16'd3};
    tbl[5]  = '{10'd0,  16'h7FFF,   16'h7FFF,   16'h7FFF};
    tbl[6]  = '{10'd1,  16'h8000,   16'h7FFF,   16'hFFFF};
    tbl[7]  = '{10'd1,  16'h8000,   16'h8000,   16'h8000};
    tbl[8]  = '{10'd1,  16'h8001,   16'h8000,   16'h8000};
    tbl[9]  = '{10'd1,  16'h7FFF,   16'h8001,   16'h0000};
    tbl[10] = '{10'd10, 16'd5,      16'd1,      16'd3};
    tbl[11] = '{10'd11, 16'd6,      16'd1,      16'd3};
    tbl[12] = '{10'd13, 16'd7,      16'd0,      16'd3};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_delayed", {16'd0, out_delayed}, 32'd0);
    chk("rst_out_mix", {16'd0, out_mix}, 32'd0);
    chk("rst_ram_wr_en", {31'd0, ram_wr_en}, 32'd0);
    chk("rst_ram_wr_addr", {22'd0, ram_wr_addr}, 32'd0);
    chk("rst_ram_wr_data", {16'd0, ram_wr_data}, 32'd0);
    chk("rst_ram_rd_addr", {22'd0, ram_rd_addr}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      send(tbl[i].d, tbl[i].s, tbl[i].ed, tbl[i].em, 1'b0, '0);

    // Clear during WAIT aborts the sample and flushes fill state.
    accept_only(10'd2, 16'h0055);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_no_wr", {31'd0, ram_wr_en}, 32'd0);
    chk("clear_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("clear_no_out_valid", {31'd0, out_valid}, 32'd0);
    hist.delete();
    send(10'd1, 16'd9, 16'd0, 16'd4, 1'b0, '0);

    for (int i = 10; i < 15; i++)
      send(10'd0, i[DW-1:0], i[DW-1:0], i[DW-1:0], 1'b0, '0);
    send(10'd4, 16'd20, 16'd11, 16'd15, 1'b1, 10'd2);
    send(10'd2, 16'd21, 16'd14, 16'd17, 1'b0, '0);

    // Reset mid-transaction behaves like clear.
    accept_only(10'd1, 16'h0077);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_wr", {31'd0, ram_wr_en}, 32'd0);
      chk("rst_mid_no_out", {31'd0, out_valid}, 32'd0);
    end
    hist.delete();

    for (int n = 0; n < 1100; n++) begin
      ed = (n >= 1023) ? 16'(n - 1023) : 16'd0;
      send(10'd1023, 16'(n), ed, mix_of(16'(n), ed), 1'b0, '0);
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
